// File: rtl/uart_rx_irq_ctrl.sv
// UART RX interrupt scheduler: error/data/timeout/THRE arbitration plus the character-timeout timer.
// Optional character-timeout logic is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_irq_ctrl #(
  parameter int unsigned TICKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_CHARS = 4,
  parameter int unsigned CNT_W         = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic [1:0] data_bit_num_i,
  input  logic       parity_en_i,
  input  logic       stop_bit_num_i,
  input  logic       fifo_en_i,
  input  logic       rx_data_valid_i,
  input  logic       rdr_empty_i,
  input  logic       fifo_rx_empty_i,
  input  logic       fifo_rx_triggered_i,
  input  logic       fifo_rx_pop_i,
  input  logic       parity_err_i,
  input  logic       stop_bit_err_i,
  input  logic       overrun_i,
  input  logic       tx_empty_i,
  input  logic       thr_write_i,
  input  logic [3:0] ier_i,
  input  logic       lsr_read_i,
  input  logic       iir_read_i,
  output logic       irq_o,
  output logic [2:0] iir_id_o,
  output logic [2:0] lsr_err_o,
  output logic       timeout_o
);

  localparam logic [2:0] ID_NONE = 3'b000;
  localparam logic [2:0] ID_THRE = 3'b001;
  localparam logic [2:0] ID_RDA  = 3'b010;
  localparam logic [2:0] ID_RLS  = 3'b011;
  localparam logic [2:0] ID_CTI  = 3'b110;

  logic [2:0] lsr_err_q;
  logic       tx_empty_d;
  logic       thre_pend_q;
  logic [2:0] iir_id_q;
  logic       irq_q;
  logic       cti_c;
  logic       rls_c;
  logic       rda_c;
  logic       thre_c;
  logic [2:0] id_c;

  // Sticky line-status errors; a new error in the read cycle survives the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) lsr_err_q <= 3'b000;
    else          lsr_err_q <= (lsr_err_q & {3{~lsr_read_i}}) | {overrun_i, stop_bit_err_i, parity_err_i};
  end

  // THRE pending: set on tx_empty rising edge, which beats any same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_empty_d  <= 1'b1;
      thre_pend_q <= 1'b0;
    end else begin
      tx_empty_d  <= tx_empty_i;
      thre_pend_q <= (tx_empty_i & ~tx_empty_d) |
                     (thre_pend_q & ~(thr_write_i | (iir_read_i & (iir_id_q == ID_THRE))));
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COUNT   = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] limit_m1_c;
  logic [3:0]       char_len_c;
  logic             timeout_q;
  logic             restart_c;

  assign char_len_c = 4'd7 + 4'(data_bit_num_i) + 4'(parity_en_i) + 4'(stop_bit_num_i);
  assign limit_m1_c = CNT_W'(TIMEOUT_CHARS * TICKS_PER_BIT * 32'(char_len_c) - 32'd1);
  assign restart_c  = rx_data_valid_i | fifo_rx_pop_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      timeout_q <= (state_n == ST_EXPIRED);
    end
  end

  // Comparison uses >= so a shortened character format mid-count still expires.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    if (!fifo_en_i || fifo_rx_empty_i) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_COUNT;
          cnt_n   = '0;
        end
        ST_COUNT: begin
          if (restart_c) begin
            cnt_n = '0;
          end else if (tick_i) begin
            if (cnt_q >= limit_m1_c) begin
              state_n = ST_EXPIRED;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_EXPIRED: begin
          if (restart_c) begin
            state_n = ST_COUNT;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign timeout_o = timeout_q;
  assign cti_c     = timeout_q & ier_i[3];
`else
  logic unused_timer_c;
  assign unused_timer_c = ^{tick_i, data_bit_num_i, parity_en_i, stop_bit_num_i,
                            rx_data_valid_i, fifo_rx_empty_i, fifo_rx_pop_i, ier_i[3]};
  assign timeout_o = 1'b0;
  assign cti_c     = 1'b0;
`endif

  assign rls_c  = (|lsr_err_q) & ier_i[2];
  assign rda_c  = (fifo_en_i ? fifo_rx_triggered_i : ~rdr_empty_i) & ier_i[0];
  assign thre_c = thre_pend_q & ier_i[1];

  always_comb begin
    id_c = ID_NONE;
    if (rls_c)       id_c = ID_RLS;
    else if (rda_c)  id_c = ID_RDA;
    else if (cti_c)  id_c = ID_CTI;
    else if (thre_c) id_c = ID_THRE;
  end

  // IIR read holds the reported ID steady for the access cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iir_id_q <= ID_NONE;
      irq_q    <= 1'b0;
    end else if (!iir_read_i) begin
      iir_id_q <= id_c;
      irq_q    <= (id_c != ID_NONE);
    end
  end

  assign irq_o     = irq_q;
  assign iir_id_o  = iir_id_q;
  assign lsr_err_o = lsr_err_q;

endmodule

// File: tb/tb_uart_rx_irq_ctrl.sv
// Directed self-checking bench for uart_rx_irq_ctrl (timer tests depend on UART_RX_TIMEOUT_EN).
module tb_uart_rx_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_i;
  logic [1:0] data_bit_num_i;
  logic       parity_en_i;
  logic       stop_bit_num_i;
  logic       fifo_en_i;
  logic       rx_data_valid_i;
  logic       rdr_empty_i;
  logic       fifo_rx_empty_i;
  logic       fifo_rx_triggered_i;
  logic       fifo_rx_pop_i;
  logic       parity_err_i;
  logic       stop_bit_err_i;
  logic       overrun_i;
  logic       tx_empty_i;
  logic       thr_write_i;
  logic [3:0] ier_i;
  logic       lsr_read_i;
  logic       iir_read_i;
  logic       irq_o;
  logic [2:0] iir_id_o;
  logic [2:0] lsr_err_o;
  logic       timeout_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  uart_rx_irq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .tick_i(tick_i), .data_bit_num_i(data_bit_num_i),
    .parity_en_i(parity_en_i), .stop_bit_num_i(stop_bit_num_i), .fifo_en_i(fifo_en_i),
    .rx_data_valid_i(rx_data_valid_i), .rdr_empty_i(rdr_empty_i),
    .fifo_rx_empty_i(fifo_rx_empty_i), .fifo_rx_triggered_i(fifo_rx_triggered_i),
    .fifo_rx_pop_i(fifo_rx_pop_i), .parity_err_i(parity_err_i),
    .stop_bit_err_i(stop_bit_err_i), .overrun_i(overrun_i), .tx_empty_i(tx_empty_i),
    .thr_write_i(thr_write_i), .ier_i(ier_i), .lsr_read_i(lsr_read_i),
    .iir_read_i(iir_read_i), .irq_o(irq_o), .iir_id_o(iir_id_o),
    .lsr_err_o(lsr_err_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    tick_i = 0; data_bit_num_i = 2'b11; parity_en_i = 0; stop_bit_num_i = 0;
    fifo_en_i = 0; rx_data_valid_i = 0; rdr_empty_i = 1; fifo_rx_empty_i = 1;
    fifo_rx_triggered_i = 0; fifo_rx_pop_i = 0; parity_err_i = 0; stop_bit_err_i = 0;
    overrun_i = 0; tx_empty_i = 0; thr_write_i = 0; ier_i = 4'b0000;
    lsr_read_i = 0; iir_read_i = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_i = 1; step();
      tick_i = 0; step();
    end
  endtask

  task automatic test_reset();
    init_inputs();
    reset_n = 0;
    step();
    check_cnt++;
    if ({irq_o, iir_id_o, lsr_err_o, timeout_o} !== 8'h00)
      $display("FAIL reset_state: got %b, want 00000000", {irq_o, iir_id_o, lsr_err_o, timeout_o});
    else pass_cnt++;
    reset_n = 1;
    step();
  endtask

  task automatic test_reset_mid();
    init_inputs();
    ier_i = 4'b1111; fifo_en_i = 1;
    apply_reset();
    fifo_rx_empty_i = 0; rx_data_valid_i = 1; step(); rx_data_valid_i = 0;
    parity_err_i = 1; step(); parity_err_i = 0;
    do_ticks(300);
    check_cnt++;
    if ({irq_o, iir_id_o, lsr_err_o} !== 7'b1_011_001)
      $display("FAIL mid_pre_reset: got %b, want 1011001", {irq_o, iir_id_o, lsr_err_o});
    else pass_cnt++;
    reset_n = 0; step();
    check_cnt++;
    if ({irq_o, iir_id_o, lsr_err_o, timeout_o} !== 8'h00)
      $display("FAIL mid_reset: got %b, want 00000000", {irq_o, iir_id_o, lsr_err_o, timeout_o});
    else pass_cnt++;
    reset_n = 1; step();
`ifdef UART_RX_TIMEOUT_EN
    do_ticks(639);
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL mid_restart_639: got %b, want 0", timeout_o);
    else pass_cnt++;
    tick_i = 1; step(); tick_i = 0;
    check_cnt++;
    if (timeout_o !== 1'b1) $display("FAIL mid_restart_640: got %b, want 1", timeout_o);
    else pass_cnt++;
`endif
  endtask

`ifdef UART_RX_TIMEOUT_EN
  task automatic test_cti_8n1();
    init_inputs();
    ier_i = 4'b1000; fifo_en_i = 1;
    apply_reset();
    fifo_rx_empty_i = 0; rx_data_valid_i = 1; step(); rx_data_valid_i = 0;
    do_ticks(639);
    check_cnt++;
    if ({timeout_o, irq_o} !== 2'b00) $display("FAIL cti8n1_639: got %b, want 00", {timeout_o, irq_o});
    else pass_cnt++;
    tick_i = 1; step(); tick_i = 0;
    check_cnt++;
    if ({timeout_o, irq_o} !== 2'b10) $display("FAIL cti8n1_640: got %b, want 10", {timeout_o, irq_o});
    else pass_cnt++;
    step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b1_110) $display("FAIL cti8n1_irq: got %b, want 1110", {irq_o, iir_id_o});
    else pass_cnt++;
    fifo_rx_pop_i = 1; step(); fifo_rx_pop_i = 0;
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL cti8n1_pop: got %b, want 0", timeout_o);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b0_000) $display("FAIL cti8n1_irq_clr: got %b, want 0000", {irq_o, iir_id_o});
    else pass_cnt++;
  endtask

  task automatic test_cti_5n1();
    init_inputs();
    data_bit_num_i = 2'b00; ier_i = 4'b1000; fifo_en_i = 1; fifo_rx_empty_i = 0;
    apply_reset();
    do_ticks(446);
    tick_i = 1; fifo_rx_pop_i = 1; step(); tick_i = 0; fifo_rx_pop_i = 0; step();
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL cti5n1_pop447: got %b, want 0", timeout_o);
    else pass_cnt++;
    do_ticks(447);
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL cti5n1_447: got %b, want 0", timeout_o);
    else pass_cnt++;
    tick_i = 1; step(); tick_i = 0;
    check_cnt++;
    if (timeout_o !== 1'b1) $display("FAIL cti5n1_448: got %b, want 1", timeout_o);
    else pass_cnt++;
  endtask

  task automatic test_valid_at_limit();
    init_inputs();
    ier_i = 4'b1000; fifo_en_i = 1; fifo_rx_empty_i = 0;
    apply_reset();
    do_ticks(639);
    tick_i = 1; rx_data_valid_i = 1; step(); tick_i = 0; rx_data_valid_i = 0;
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL valid_at_limit: got %b, want 0", timeout_o);
    else pass_cnt++;
    do_ticks(639);
    check_cnt++;
    if (timeout_o !== 1'b0) $display("FAIL valid_limit_639: got %b, want 0", timeout_o);
    else pass_cnt++;
    tick_i = 1; step(); tick_i = 0;
    check_cnt++;
    if (timeout_o !== 1'b1) $display("FAIL valid_limit_640: got %b, want 1", timeout_o);
    else pass_cnt++;
  endtask
`else
  task automatic test_cti_disabled();
    init_inputs();
    ier_i = 4'b1000; fifo_en_i = 1; fifo_rx_empty_i = 0;
    apply_reset();
    do_ticks(700);
    check_cnt++;
    if ({timeout_o, irq_o, iir_id_o} !== 5'b0_0_000)
      $display("FAIL cti_disabled: got %b, want 00000", {timeout_o, irq_o, iir_id_o});
    else pass_cnt++;
  endtask
`endif

  task automatic test_priority();
    init_inputs();
    ier_i = 4'b0111; fifo_en_i = 1; fifo_rx_empty_i = 0;
    apply_reset();
    fifo_rx_triggered_i = 1; tx_empty_i = 1;
    step(); step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b1_010) $display("FAIL prio_rda_thre: got %b, want 1010", {irq_o, iir_id_o});
    else pass_cnt++;
    parity_err_i = 1; step(); parity_err_i = 0; step();
    check_cnt++;
    if ({iir_id_o, lsr_err_o} !== 6'b011_001) $display("FAIL prio_rls: got %b, want 011001", {iir_id_o, lsr_err_o});
    else pass_cnt++;
    lsr_read_i = 1; step(); lsr_read_i = 0;
    check_cnt++;
    if (lsr_err_o !== 3'b000) $display("FAIL prio_lsr_clr: got %b, want 000", lsr_err_o);
    else pass_cnt++;
    step();
    check_cnt++;
    if (iir_id_o !== 3'b010) $display("FAIL prio_after_lsr: got %b, want 010", iir_id_o);
    else pass_cnt++;
    fifo_rx_triggered_i = 0; step();
    check_cnt++;
    if (iir_id_o !== 3'b001) $display("FAIL prio_thre: got %b, want 001", iir_id_o);
    else pass_cnt++;
    iir_read_i = 1; step(); iir_read_i = 0; step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b0_000) $display("FAIL prio_iir_read: got %b, want 0000", {irq_o, iir_id_o});
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    init_inputs();
    ier_i = 4'b0100;
    apply_reset();
    stop_bit_err_i = 1; lsr_read_i = 1; step(); stop_bit_err_i = 0; lsr_read_i = 0;
    check_cnt++;
    if (lsr_err_o !== 3'b010) $display("FAIL sim_set_clr: got %b, want 010", lsr_err_o);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b1_011) $display("FAIL sim_rls: got %b, want 1011", {irq_o, iir_id_o});
    else pass_cnt++;
    overrun_i = 1; step(); overrun_i = 0;
    check_cnt++;
    if (lsr_err_o !== 3'b110) $display("FAIL sim_overrun: got %b, want 110", lsr_err_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    init_inputs();
    ier_i = 4'b0010;
    apply_reset();
    tx_empty_i = 1; step(); step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b1_001) $display("FAIL b2b_thre: got %b, want 1001", {irq_o, iir_id_o});
    else pass_cnt++;
    thr_write_i = 1; tx_empty_i = 0; step(); thr_write_i = 0; step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b0_000) $display("FAIL b2b_thr_write: got %b, want 0000", {irq_o, iir_id_o});
    else pass_cnt++;
    ier_i = 4'b0001; rdr_empty_i = 0; iir_read_i = 1; step(); iir_read_i = 0;
    check_cnt++;
    if (iir_id_o !== 3'b000) $display("FAIL b2b_freeze: got %b, want 000", iir_id_o);
    else pass_cnt++;
    step();
    check_cnt++;
    if (iir_id_o !== 3'b010) $display("FAIL b2b_unfreeze: got %b, want 010", iir_id_o);
    else pass_cnt++;
  endtask

  task automatic test_non_fifo();
    init_inputs();
    ier_i = 4'b0001;
    apply_reset();
    fifo_rx_empty_i = 0; rdr_empty_i = 0;
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b0_000) $display("FAIL nf_before_edge: got %b, want 0000", {irq_o, iir_id_o});
    else pass_cnt++;
    step();
    check_cnt++;
    if ({irq_o, iir_id_o} !== 4'b1_010) $display("FAIL nf_rda: got %b, want 1010", {irq_o, iir_id_o});
    else pass_cnt++;
    ier_i = 4'b1001;
    do_ticks(700);
    check_cnt++;
    if ({timeout_o, iir_id_o} !== 4'b0_010) $display("FAIL nf_no_timer: got %b, want 0010", {timeout_o, iir_id_o});
    else pass_cnt++;
  endtask

  initial begin
    init_inputs();
    reset_n = 0;
    test_reset();
    test_reset_mid();
`ifdef UART_RX_TIMEOUT_EN
    test_cti_8n1();
    test_cti_5n1();
    test_valid_at_limit();
`else
    test_cti_disabled();
`endif
    test_priority();
    test_simultaneous();
    test_back_to_back();
    test_non_fifo();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
